// File: rtl/jk_counter_sequencer.sv
// Sequences a WIDTH-bit JK-style counter from its start value to a latched target,
// exporting the per-bit toggle mask applied each cycle so a mirrored JK bank can track it.
module jk_counter_sequencer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] target,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] jk_s;
  logic             step_s;

  // Ripple toggle mask: bit i flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    logic chain_v;
    chain_v = 1'b1;
    mask_s  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask_s[i] = chain_v;
      chain_v   = chain_v & (dir_q ? count_q[i] : ~count_q[i]);
    end
  end

  // A step is applied only in RUN when not aborting, not matched and not paused.
  always_comb begin
    step_s = (state_q == S_RUN) && !abort && (count_q != tgt_q) && !pause;
    if (step_s) begin
      jk_s = mask_s;
    end else begin
      jk_s = '0;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tgt_d   = target;
          dir_d   = up_dn;
          count_d = up_dn ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (count_q == tgt_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q ^ jk_s;
          busy_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      tgt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign jk_j  = jk_s;
  assign jk_k  = jk_s;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_jk_counter_sequencer.sv
// Self-checking bench for jk_counter_sequencer: directed scenarios plus a randomized
// run compared against a cycle-level arithmetic reference model.
module tb_jk_counter_sequencer;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         up_dn = 1'b0;
  logic [W-1:0] target = '0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] count;
  logic [W-1:0] jk_j;
  logic [W-1:0] jk_k;
  logic         busy;
  logic         done;

  int n_vec = 0;
  int n_err = 0;

  jk_counter_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .up_dn(up_dn), .target(target),
    .pause(pause), .abort(abort), .count(count), .jk_j(jk_j), .jk_k(jk_k),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    tick();
  endtask

  // Issues a one-cycle start; afterwards the bench sits in cycle 1 of the run.
  task automatic do_start(input logic dir, input logic [W-1:0] tgt);
    start = 1'b1; up_dn = dir; target = tgt;
    tick();
    start = 1'b0; target = '0; up_dn = 1'b0;
  endtask

  // Advances until done is high, returning the cycle index relative to the start cycle.
  task automatic wait_done(input int from_cyc, output int cyc);
    cyc = from_cyc;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int k;
    do_reset();
    n_vec++; if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin n_err++;
      $display("FAIL reset_idle: count=%0d busy=%b done=%b, need 0/0/0", count, busy, done); end
    do_start(1'b1, 3'd5);
    for (k = 0; k < 3; k++) tick();
    n_vec++; if (count !== 3'd3) begin n_err++;
      $display("FAIL reset_pre: count=%0d, need 3", count); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || jk_j !== 3'd0 || jk_k !== 3'd0) begin n_err++;
      $display("FAIL reset_async: count=%0d busy=%b done=%b jk=%b/%b, need 0/0/0/000", count, busy, done, jk_j, jk_k); end
    #2 rst = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0 || count !== 3'd0) begin n_err++;
      $display("FAIL reset_release: busy=%b count=%0d, need 0/0", busy, count); end
    do_start(1'b1, 3'd1);
    n_vec++; if (busy !== 1'b1) begin n_err++;
      $display("FAIL reset_then_start: busy=%b, need 1", busy); end
    do_reset();
  endtask

  task automatic test_up_run();
    logic [W-1:0] exp_jk [5] = '{3'b001, 3'b011, 3'b001, 3'b111, 3'b001};
    int cyc;
    do_start(1'b1, 3'd5);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_vec++; if (count !== 3'(k) || jk_j !== exp_jk[k] || jk_k !== exp_jk[k] || busy !== 1'b1) begin n_err++;
        $display("FAIL up_step%0d: count=%0d jk=%b/%b busy=%b, need %0d/%b", k, count, jk_j, jk_k, busy, k, exp_jk[k]); end
      tick();
    end
    n_vec++; if (count !== 3'd5 || jk_j !== 3'd0 || done !== 1'b0) begin n_err++;
      $display("FAIL up_match: count=%0d jk=%b done=%b, need 5/000/0", count, jk_j, done); end
    wait_done(6, cyc);
    n_vec++; if (cyc !== 7 || busy !== 1'b0 || count !== 3'd5) begin n_err++;
      $display("FAIL up_latency: cyc=%0d busy=%b count=%0d, need 7/0/5", cyc, busy, count); end
    tick();
    n_vec++; if (done !== 1'b0 || count !== 3'd5) begin n_err++;
      $display("FAIL up_after: done=%b count=%0d, need 0/5", done, count); end
  endtask

  task automatic test_down_run();
    int cyc;
    do_start(1'b0, 3'd2);
    #1;
    n_vec++; if (count !== 3'd7 || jk_j !== 3'b001) begin n_err++;
      $display("FAIL down_first: count=%0d jk=%b, need 7/001", count, jk_j); end
    tick();
    n_vec++; if (count !== 3'd6 || jk_j !== 3'b011) begin n_err++;
      $display("FAIL down_second: count=%0d jk=%b, need 6/011", count, jk_j); end
    wait_done(2, cyc);
    n_vec++; if (cyc !== 7 || count !== 3'd2) begin n_err++;
      $display("FAIL down_latency: cyc=%0d count=%0d, need 7/2", cyc, count); end
    tick();
  endtask

  task automatic test_pause();
    int cyc;
    do_start(1'b1, 3'd3);
    tick();
    pause = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++; if (count !== 3'd1 || jk_j !== 3'd0) begin n_err++;
        $display("FAIL pause_hold%0d: count=%0d jk=%b, need 1/000", k, count, jk_j); end
      tick();
    end
    pause = 1'b0;
    n_vec++; if (count !== 3'd1) begin n_err++;
      $display("FAIL pause_release: count=%0d, need 1", count); end
    wait_done(4, cyc);
    n_vec++; if (cyc !== 7 || count !== 3'd3) begin n_err++;
      $display("FAIL pause_latency: cyc=%0d count=%0d, need 7/3", cyc, count); end
    tick();
  endtask

  task automatic test_abort();
    bit seen_done;
    do_start(1'b1, 3'd6);
    for (int k = 0; k < 4; k++) tick();
    abort = 1'b1;
    #1;
    n_vec++; if (count !== 3'd4 || jk_j !== 3'd0) begin n_err++;
      $display("FAIL abort_cycle: count=%0d jk=%b, need 4/000", count, jk_j); end
    tick();
    abort = 1'b0;
    seen_done = done;
    n_vec++; if (busy !== 1'b0 || count !== 3'd4) begin n_err++;
      $display("FAIL abort_idle: busy=%b count=%0d, need 0/4", busy, count); end
    for (int k = 0; k < 4; k++) begin tick(); seen_done |= done; end
    n_vec++; if (seen_done !== 1'b0 || count !== 3'd4) begin n_err++;
      $display("FAIL abort_nodone: done_seen=%b count=%0d, need 0/4", seen_done, count); end
    // abort coincident with the target match
    do_start(1'b1, 3'd2);
    tick(); tick();
    abort = 1'b1;
    #1;
    n_vec++; if (count !== 3'd2 || jk_j !== 3'd0) begin n_err++;
      $display("FAIL abort_match_cycle: count=%0d jk=%b, need 2/000", count, jk_j); end
    tick();
    abort = 1'b0;
    seen_done = done;
    tick();
    seen_done |= done;
    n_vec++; if (seen_done !== 1'b0 || busy !== 1'b0) begin n_err++;
      $display("FAIL abort_match: done_seen=%b busy=%b, need 0/0", seen_done, busy); end
  endtask

  task automatic test_edges();
    int cyc;
    do_start(1'b1, 3'd0);
    #1;
    n_vec++; if (jk_j !== 3'd0) begin n_err++;
      $display("FAIL eq_start_jk: jk=%b, need 000", jk_j); end
    wait_done(1, cyc);
    n_vec++; if (cyc !== 2 || count !== 3'd0) begin n_err++;
      $display("FAIL eq_start_latency: cyc=%0d count=%0d, need 2/0", cyc, count); end
    tick();
    // start during RUN and DONE must be ignored
    do_start(1'b1, 3'd4);
    tick();
    start = 1'b1; up_dn = 1'b0; target = 3'd1;
    tick();
    start = 1'b0;
    wait_done(3, cyc);
    n_vec++; if (cyc !== 6 || count !== 3'd4) begin n_err++;
      $display("FAIL start_in_run: cyc=%0d count=%0d, need 6/4", cyc, count); end
    start = 1'b1; up_dn = 1'b0; target = 3'd1;
    tick();
    start = 1'b0;
    n_vec++; if (busy !== 1'b0 || count !== 3'd4 || done !== 1'b0) begin n_err++;
      $display("FAIL start_in_done: busy=%b count=%0d done=%b, need 0/4/0", busy, count, done); end
    // full-range up run
    do_start(1'b1, 3'd7);
    for (int k = 0; k < 3; k++) tick();
    #1;
    n_vec++; if (count !== 3'd3 || jk_j !== 3'b111) begin n_err++;
      $display("FAIL max_carry: count=%0d jk=%b, need 3/111", count, jk_j); end
    wait_done(4, cyc);
    n_vec++; if (cyc !== 9 || count !== 3'd7) begin n_err++;
      $display("FAIL max_latency: cyc=%0d count=%0d, need 9/7", cyc, count); end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] m_count, m_tgt, nxt, exp_jk;
    logic m_dir, m_busy, m_done;
    int m_mode;  // 0 idle, 1 counting, 2 completion cycle
    do_reset();
    m_count = '0; m_tgt = '0; m_dir = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_mode = 0;
    for (int c = 0; c < 400; c++) begin
      start  = ($urandom_range(0, 3) == 0);
      up_dn  = 1'($urandom_range(0, 1));
      target = W'($urandom_range(0, 7));
      pause  = ($urandom_range(0, 4) == 0);
      abort  = ($urandom_range(0, 15) == 0);
      #1;
      nxt = m_count;
      exp_jk = '0;
      if (m_mode == 1 && !abort && m_count != m_tgt && !pause) begin
        nxt = m_dir ? m_count + 3'd1 : m_count - 3'd1;
        exp_jk = m_count ^ nxt;
      end
      n_vec++; if (jk_j !== exp_jk || jk_k !== exp_jk) begin n_err++;
        $display("FAIL rnd_jk c%0d: jk=%b/%b, need %b", c, jk_j, jk_k, exp_jk); end
      m_done = 1'b0;
      if (m_mode == 0) begin
        if (start) begin
          m_tgt = target; m_dir = up_dn; m_count = up_dn ? 3'd0 : 3'd7;
          m_mode = 1; m_busy = 1'b1;
        end
      end else if (m_mode == 1) begin
        if (abort) begin
          m_mode = 0; m_busy = 1'b0;
        end else if (m_count == m_tgt) begin
          m_mode = 2; m_busy = 1'b0; m_done = 1'b1;
        end else begin
          m_count = nxt;
        end
      end else begin
        m_mode = 0;
      end
      tick();
      n_vec++; if (count !== m_count || busy !== m_busy || done !== m_done) begin n_err++;
        $display("FAIL rnd_state c%0d: count=%0d busy=%b done=%b, need %0d/%b/%b", c, count, busy, done, m_count, m_busy, m_done); end
    end
    start = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_run();
    test_down_run();
    test_pause();
    test_abort();
    test_edges();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
